// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serialising memory controller: FSM states,
// size codes, requester ids and the per-request byte count helper.
package mem_ctrl_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        True_v    = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic REQ_INST = 1'b0;
    localparam logic REQ_DATA = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StInstRd,
        StDataRd,
        StDataWr,
        StDone
    } state_e;

    // Fetches are always a full word; size code 3 is treated as a word.
    function automatic logic [2:0] byte_count(input logic is_data, input logic [1:0] size);
        logic [2:0] n;
        n = 3'd4;
        if (is_data) begin
            case (size)
                SZ_BYTE: n = 3'd1;
                SZ_HALF: n = 3'd2;
                default: n = 3'd4;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Grant logic between fetch and data requesters. With MEM_CTRL_RR_EN defined a
// 1-bit last-served pointer alternates ties; otherwise data always wins.
module mem_arbiter
    import mem_ctrl_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rdy,
    input  logic i_inst_req,
    input  logic i_data_req,
    input  logic i_upd,
    input  logic i_served,
    output logic o_grant_vld,
    output logic o_grant_id
);

    assign o_grant_vld = i_inst_req | i_data_req;

`ifdef MEM_CTRL_RR_EN
    logic r_last;

    always_ff @(posedge i_clk) begin
        if (i_rst == RstEnable) begin
            r_last <= REQ_INST;
        end else if (i_rdy && i_upd) begin
            r_last <= i_served;
        end
    end

    // On a tie the port that was not served last wins.
    always_comb begin
        if (i_inst_req && i_data_req) begin
            o_grant_id = (r_last == REQ_DATA) ? REQ_INST : REQ_DATA;
        end else begin
            o_grant_id = i_data_req ? REQ_DATA : REQ_INST;
        end
    end
`else
    logic w_unused;
    assign w_unused   = ^{i_clk, i_rst, i_rdy, i_upd, i_served};
    assign o_grant_id = i_data_req ? REQ_DATA : REQ_INST;
`endif

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serialising memory controller sharing one byte-wide RAM port between
// fetch and load/store; tie policy selected by MEM_CTRL_RR_EN (see mem_arbiter).
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              inst_re,
    input  logic [31:0]       inst_addr,
    output logic [31:0]       inst_data,
    output logic              inst_busy,
    output logic              inst_done,
    input  logic              data_re,
    input  logic              data_we,
    input  logic [31:0]       data_addr,
    input  logic [1:0]        data_size,
    input  logic [31:0]       data_wdata,
    output logic [31:0]       data_rdata,
    output logic              data_busy,
    output logic              data_done,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr
);

    state_e      r_state, w_state_nxt;
    logic [2:0]  r_cnt;
    logic [31:0] r_base, r_wdata, r_buf, w_rbuf, w_addr;
    logic [1:0]  r_size, r_cap_lane;
    logic        r_req, r_cap_vld;
    logic        w_data_req, w_grant_vld, w_grant_id, w_grant, w_last, w_in_rd, w_serve;
    logic [2:0]  w_n;

    assign w_data_req = data_re | data_we;
    assign w_n        = byte_count(r_req, r_size);
    assign w_last     = (r_cnt == (w_n - 3'd1));
    assign w_addr     = r_base + {29'b0, r_cnt};
    assign w_in_rd    = (r_state == StInstRd) || (r_state == StDataRd);
    assign w_grant    = (r_state == StIdle) && w_grant_vld;
    assign w_serve    = (r_state == StDone);

    mem_arbiter u_arbiter (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_rdy       (rdy),
        .i_inst_req  (inst_re),
        .i_data_req  (w_data_req),
        .i_upd       (w_serve),
        .i_served    (r_req),
        .o_grant_vld (w_grant_vld),
        .o_grant_id  (w_grant_id)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state <= StIdle;
        end else if (rdy) begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_grant_vld) begin
                    if (w_grant_id == REQ_INST) w_state_nxt = StInstRd;
                    else if (data_we)           w_state_nxt = StDataWr;
                    else                        w_state_nxt = StDataRd;
                end
            end
            StInstRd, StDataRd, StDataWr: begin
                if (w_last) w_state_nxt = StDone;
            end
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_cnt   <= 3'd0;
            r_base  <= ZeroWord;
            r_size  <= SZ_BYTE;
            r_wdata <= ZeroWord;
            r_req   <= REQ_INST;
        end else if (rdy) begin
            if (w_grant) begin
                r_cnt   <= 3'd0;
                r_req   <= w_grant_id;
                r_wdata <= data_wdata;
                if (w_grant_id == REQ_INST) begin
                    r_base <= inst_addr;
                    r_size <= SZ_WORD;
                end else begin
                    r_base <= data_addr;
                    r_size <= data_size;
                end
            end else if ((w_in_rd || r_state == StDataWr) && !w_last) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    // RAM answers one cycle after an issued beat even while rdy is low, so the
    // capture pipeline runs independently of rdy.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_buf      <= ZeroWord;
            r_cap_vld  <= 1'b0;
            r_cap_lane <= 2'd0;
        end else begin
            r_cap_vld  <= w_in_rd && rdy;
            r_cap_lane <= r_cnt[1:0];
            if (rdy && w_grant)  r_buf <= ZeroWord;
            else if (r_cap_vld)  r_buf <= w_rbuf;
        end
    end

    // Last lane arrives during DONE, so merge it in combinationally.
    always_comb begin
        w_rbuf = r_buf;
        if (r_cap_vld) w_rbuf[{r_cap_lane, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        inst_done  = 1'b0;
        data_done  = 1'b0;
        inst_data  = ZeroWord;
        data_rdata = ZeroWord;
        mem_wr     = 1'b0;
        mem_dout   = 8'h00;
        mem_a      = '0;
        if (w_serve && r_req == REQ_INST) inst_data  = w_rbuf;
        if (w_serve && r_req == REQ_DATA) data_rdata = w_rbuf;
        if (w_serve && rdy) begin
            inst_done = (r_req == REQ_INST);
            data_done = (r_req == REQ_DATA);
        end
        if (w_in_rd || r_state == StDataWr) mem_a = w_addr[ADDR_W-1:0];
        if (r_state == StDataWr && rdy) begin
            mem_wr   = True_v;
            mem_dout = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
        end
        inst_busy = inst_re && !(w_serve && r_req == REQ_INST);
        data_busy = w_data_req && !(w_serve && r_req == REQ_DATA);
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a per-cycle transaction model plus directed
// scenarios with literal expectations. Honours MEM_CTRL_RR_EN for tie results.
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst, rdy, inst_re, inst_busy, inst_done;
    logic [31:0] inst_addr, inst_data;
    logic        data_re, data_we, data_busy, data_done;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [1:0]  data_size;
    logic [7:0]  mem_din = 8'h00;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .rdy        (rdy),
        .inst_re    (inst_re),
        .inst_addr  (inst_addr),
        .inst_data  (inst_data),
        .inst_busy  (inst_busy),
        .inst_done  (inst_done),
        .data_re    (data_re),
        .data_we    (data_we),
        .data_addr  (data_addr),
        .data_size  (data_size),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .data_busy  (data_busy),
        .data_done  (data_done),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_a      (mem_a),
        .mem_wr     (mem_wr)
    );

    logic [7:0]  ram    [logic [31:0]];
    logic [7:0]  shadow [logic [31:0]];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [31:0] alog [16];
    logic        chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: no completion within the cycle budget (cycle %0d)", name, cyc);
    endtask

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    function automatic logic [7:0] sh_rd(input logic [31:0] a);
        return shadow.exists(a) ? shadow[a] : 8'h00;
    endfunction

    task automatic ram_set(input logic [31:0] a, input logic [7:0] v);
        ram[a]    = v;
        shadow[a] = v;
    endtask

    function automatic int size_n(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] base, input int n);
        logic [31:0] v;
        v = 32'h0;
        for (int k = 0; k < n; k++) v[8*k +: 8] = sh_rd(base + k);
        return v;
    endfunction

    // RAM: writes land at the edge, read data appears one cycle after the address.
    initial forever begin
        @(posedge clk);
        cyc++;
        mem_din <= ram_rd(mem_a);
        if (mem_wr) ram[mem_a] = mem_dout;
    end

    // Transaction model: position p counts rdy-high cycles since the grant;
    // p = 1..n are byte beats, p = n+1 is the completion cycle.
    logic        m_act = 1'b0, m_port = 1'b0, m_we = 1'b0;
    logic [31:0] m_base = 32'h0, m_wdata = 32'h0;
    int          m_n = 0, m_p = 0;
`ifdef MEM_CTRL_RR_EN
    logic        m_last = 1'b0;
`endif

    initial forever begin
        logic       d_req, e_wr, e_done, e_fin;
        logic [7:0] e_dout;
        @(negedge clk);
        if (chk_en) begin
            d_req = data_re | data_we;
            if (!m_act && !rst && rdy && (inst_re || d_req)) begin
                if (inst_re && d_req) begin
`ifdef MEM_CTRL_RR_EN
                    m_port = ~m_last;
`else
                    m_port = 1'b1;
`endif
                end else begin
                    m_port = d_req;
                end
                m_act = 1'b1;
                m_p   = 0;
                if (m_port) begin
                    m_base = data_addr; m_we = data_we;
                    m_n = size_n(data_size); m_wdata = data_wdata;
                end else begin
                    m_base = inst_addr; m_we = 1'b0; m_n = 4; m_wdata = 32'h0;
                end
            end
            e_fin  = m_act && (m_p == m_n + 1);
            e_wr   = m_act && m_we && (m_p >= 1) && (m_p <= m_n) && rdy;
            e_dout = 8'h00;
            if (e_wr) e_dout = m_wdata[8*(m_p-1) +: 8];
            e_done = e_fin && rdy;
            chk("mem_wr", 32'(mem_wr), 32'(e_wr));
            chk("mem_dout", 32'(mem_dout), 32'(e_dout));
            if (m_act && m_p >= 1 && m_p <= m_n) chk("mem_a", mem_a, m_base + m_p - 1);
            chk("inst_done", 32'(inst_done), 32'(e_done && !m_port));
            chk("data_done", 32'(data_done), 32'(e_done && m_port));
            if (e_done && !m_port) chk("inst_data", inst_data, mdl_read(m_base, 4));
            if (e_done && m_port)
                chk("data_rdata", data_rdata, m_we ? 32'h0 : mdl_read(m_base, m_n));
            chk("inst_busy", 32'(inst_busy), 32'(inst_re && !(e_fin && !m_port)));
            chk("data_busy", 32'(data_busy), 32'(d_req && !(e_fin && m_port)));
            if (e_wr) shadow[m_base + m_p - 1] = e_dout;
            if (rst) begin
                m_act = 1'b0;
                m_p   = 0;
`ifdef MEM_CTRL_RR_EN
                m_last = 1'b0;
`endif
            end else if (rdy && m_act) begin
                if (e_done) begin
                    m_act = 1'b0;
`ifdef MEM_CTRL_RR_EN
                    m_last = m_port;
`endif
                end else begin
                    m_p++;
                end
            end
        end
    end

    task automatic run(input logic is_inst, input logic we, input logic [31:0] addr,
                       input logic [1:0] sz, input logic [31:0] wd, input int stall_at,
                       output int lat, output logic [31:0] rd);
        int t0;
        bit got;
        got = 0; lat = 0; rd = 32'h0; wr_cnt = 0;
        for (int i = 0; i < 16; i++) alog[i] = 32'h0;
        @(posedge clk); #1;
        if (is_inst) begin
            inst_re = 1'b1; inst_addr = addr;
        end else begin
            data_re = !we; data_we = we; data_addr = addr; data_size = sz; data_wdata = wd;
        end
        t0 = cyc;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (cyc - t0 < 16) alog[cyc - t0] = mem_a;
            if (mem_wr) wr_cnt++;
            if ((is_inst && inst_done) || (!is_inst && data_done)) begin
                got = 1;
                lat = cyc - t0 + 1;
                rd  = is_inst ? inst_data : data_rdata;
            end else begin
                @(posedge clk); #1;
                rdy = !(stall_at > 0 && (cyc - t0) >= stall_at && (cyc - t0) < stall_at + 3);
            end
        end
        if (!got) fail_now("done_timeout");
        @(posedge clk); #1;
        inst_re = 1'b0; data_re = 1'b0; data_we = 1'b0; rdy = 1'b1;
    endtask

    task automatic wait_any(output int port);
        port = 2;
        for (int i = 0; i < 40 && port == 2; i++) begin
            @(negedge clk);
            if (data_done)      port = 1;
            else if (inst_done) port = 0;
        end
        if (port == 2) fail_now("tie_timeout");
    endtask

    initial begin
        int          lat, p, rst_done;
        logic [31:0] rd;
        rst = 1'b1; rdy = 1'b1; inst_re = 1'b0; inst_addr = 32'h0;
        data_re = 1'b0; data_we = 1'b0; data_addr = 32'h0; data_size = 2'd0; data_wdata = 32'h0;
        ram_set(32'h100, 8'h13); ram_set(32'h101, 8'h05);
        ram_set(32'h102, 8'h10); ram_set(32'h103, 8'h00);
        ram_set(32'h2003, 8'hAB);
        ram_set(32'h3000, 8'h11); ram_set(32'h3001, 8'h22);
        ram_set(32'h3002, 8'h33); ram_set(32'h3003, 8'h44);
        ram_set(32'hFFFF_FFFE, 8'h78); ram_set(32'hFFFF_FFFF, 8'h56);
        ram_set(32'h0, 8'h34); ram_set(32'h1, 8'h12);
        ram_set(32'h400, 8'hA1); ram_set(32'h401, 8'hB2);
        ram_set(32'h402, 8'hC3); ram_set(32'h403, 8'hD4);
        ram_set(32'h500, 8'h01); ram_set(32'h501, 8'h02);
        ram_set(32'h502, 8'h03); ram_set(32'h503, 8'h04);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_inst_data", inst_data, 32'h0);
        chk("rst_data_rdata", data_rdata, 32'h0);
        chk("rst_dones", 32'({inst_done, data_done}), 32'h0);
        chk_en = 1'b1;

        run(1'b1, 1'b0, 32'h100, 2'd2, 32'h0, 0, lat, rd);
        chk("fetch_data", rd, 32'h0010_0513);
        chk("fetch_latency", 32'(lat), 32'd6);
        for (int k = 0; k < 4; k++) chk("fetch_addr", alog[k+1], 32'h100 + k);
        chk("fetch_no_write", 32'(wr_cnt), 32'd0);

        run(1'b0, 1'b0, 32'h2003, 2'd0, 32'h0, 0, lat, rd);
        chk("byte_load", rd, 32'h0000_00AB);
        chk("byte_load_latency", 32'(lat), 32'd3);

        run(1'b0, 1'b0, 32'h100, 2'd1, 32'h0, 0, lat, rd);
        chk("half_load", rd, 32'h0000_0513);

        run(1'b0, 1'b1, 32'h3000, 2'd2, 32'hDEAD_BEEF, 0, lat, rd);
        chk("store_beats", 32'(wr_cnt), 32'd4);
        chk("store_b0", 32'(ram_rd(32'h3000)), 32'hEF);
        chk("store_b1", 32'(ram_rd(32'h3001)), 32'hBE);
        chk("store_b2", 32'(ram_rd(32'h3002)), 32'hAD);
        chk("store_b3", 32'(ram_rd(32'h3003)), 32'hDE);

        run(1'b0, 1'b1, 32'h3001, 2'd0, 32'h0000_005A, 0, lat, rd);
        chk("byte_store_beats", 32'(wr_cnt), 32'd1);
        run(1'b0, 1'b0, 32'h3000, 2'd1, 32'h0, 0, lat, rd);
        chk("half_after_byte_store", rd, 32'h0000_5AEF);
        run(1'b0, 1'b0, 32'h100, 2'd3, 32'h0, 0, lat, rd);
        chk("size3_is_word", rd, 32'h0010_0513);

        run(1'b0, 1'b0, 32'hFFFF_FFFE, 2'd2, 32'h0, 0, lat, rd);
        chk("wrap_a0", alog[1], 32'hFFFF_FFFE);
        chk("wrap_a1", alog[2], 32'hFFFF_FFFF);
        chk("wrap_a2", alog[3], 32'h0000_0000);
        chk("wrap_a3", alog[4], 32'h0000_0001);
        chk("wrap_data", rd, 32'h1234_5678);

        run(1'b0, 1'b0, 32'h400, 2'd2, 32'h0, 3, lat, rd);
        chk("stall_data", rd, 32'hD4C3_B2A1);
        chk("stall_latency", 32'(lat), 32'd9);

        // Tie: both rise together and stay high through the first completion.
        @(posedge clk); #1;
        inst_re = 1'b1; inst_addr = 32'h100;
        data_re = 1'b1; data_addr = 32'h2003; data_size = 2'd0;
        wait_any(p);
        chk("tie_first", 32'(p), 32'd1);
        wait_any(p);
`ifdef MEM_CTRL_RR_EN
        chk("tie_second", 32'(p), 32'd0);
`else
        chk("tie_second", 32'(p), 32'd1);
`endif
        @(posedge clk); #1;
        if (p == 1) data_re = 1'b0;
        else        inst_re = 1'b0;
        wait_any(p);
        chk("tie_last", 32'(p), data_re ? 32'd1 : 32'd0);
        @(posedge clk); #1;
        inst_re = 1'b0; data_re = 1'b0;

        // Reset after two bytes of a word store.
        @(posedge clk); #1;
        data_we = 1'b1; data_addr = 32'h500; data_size = 2'd2; data_wdata = 32'h9988_7766;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; data_we = 1'b0;
        rst_done = 0;
        @(negedge clk);
        chk("rst_abort_wr", 32'(mem_wr), 32'h0);
        repeat (4) begin
            @(negedge clk);
            if (data_done) rst_done++;
        end
        chk("rst_abort_no_done", 32'(rst_done), 32'd0);
        chk("rst_partial_b0", 32'(ram_rd(32'h500)), 32'h66);
        chk("rst_partial_b1", 32'(ram_rd(32'h501)), 32'h77);
        chk("rst_partial_b2", 32'(ram_rd(32'h502)), 32'h03);
        chk("rst_partial_b3", 32'(ram_rd(32'h503)), 32'h04);

        run(1'b0, 1'b1, 32'h500, 2'd1, 32'h0000_CAFE, 0, lat, rd);
        run(1'b0, 1'b0, 32'h500, 2'd2, 32'h0, 0, lat, rd);
        chk("post_rst_word", rd, 32'h0403_CAFE);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
